ysyx_22040125_axi_rmaster: RTL and testbench

YSYX_22040125_AXI_RMASTER -- requirements
Module: ysyx_22040125_axi_rmaster

---
 rtl/ysyx_22040125_axi_rmaster.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22040125_axi_rmaster.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040125_axi_rmaster.sv
// AXI4 read master: round-robin arbitration of NREQ requesters onto a single AR/R channel,
// one burst outstanding, beats forwarded to the owner one cycle after the R handshake.
module ysyx_22040125_axi_rmaster #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DW     = 64,
    parameter int unsigned AW     = 32,
    parameter int unsigned MAXLEN = 8
) (
    input  logic              aclk,
    input  logic              areset,
    output logic [3:0]        arid,
    output logic [AW-1:0]     araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DW-1:0]     rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_len,
    input  logic [NREQ*3-1:0] req_size,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output logic [DW-1:0]     resp_data,
    output logic              resp_last,
    output logic              resp_err
);

    localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  LenMax  = 8'(MAXLEN - 1);
    localparam logic [2:0]  SizeMax = 3'($clog2(DW / 8));

    typedef enum logic [1:0] {StIdle, StAr, StR, StErr} state_e;

    state_e            state_q;
    logic [IW-1:0]     rr_q, owner_q;
    logic [AW-1:0]     addr_q;
    logic [7:0]        len_q, cnt_q;
    logic [2:0]        size_q;
    logic              err_q;
    logic [NREQ-1:0]   resp_valid_q;
    logic [DW-1:0]     resp_data_q;
    logic              resp_last_q, resp_err_q;

    logic              gnt_found;
    logic [IW-1:0]     gnt_idx, cand;
    logic [AW-1:0]     g_addr;
    logic [7:0]        g_len;
    logic [2:0]        g_size;
    logic [NREQ-1:0]   owner_oh;
    logic              beat_final, beat_err;

    // Scan requesters starting at the round-robin pointer; first valid one wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = IW'((int'(rr_q) + k) % int'(NREQ));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        g_addr     = req_addr[int'(gnt_idx)*AW +: AW];
        g_len      = req_len[int'(gnt_idx)*8 +: 8];
        g_size     = req_size[int'(gnt_idx)*3 +: 3];
        owner_oh   = NREQ'(1) << owner_q;
        beat_final = (cnt_q == len_q);
        beat_err   = err_q | (rresp != 2'b00) | (rid != 4'(owner_q)) | (rlast != beat_final);
        req_ready  = (state_q == StIdle && gnt_found && !areset) ? (NREQ'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            rr_q         <= '0;
            owner_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            size_q       <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            resp_last_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        owner_q <= gnt_idx;
                        addr_q  <= g_addr;
                        size_q  <= g_size;
                        cnt_q   <= '0;
                        rr_q    <= IW'((int'(gnt_idx) + 1) % int'(NREQ));
                        if (g_len > LenMax) begin
                            len_q <= LenMax;
                            err_q <= 1'b1;
                        end else begin
                            len_q <= g_len;
                            err_q <= 1'b0;
                        end
                        // Unsupported beat size: answer locally with a single error beat.
                        if (g_size > SizeMax) begin
                            state_q      <= StErr;
                            resp_valid_q <= NREQ'(1) << gnt_idx;
                            resp_data_q  <= '0;
                            resp_last_q  <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q <= StAr;
                        end
                    end
                end
                StAr: begin
                    if (arready) state_q <= StR;
                end
                StR: begin
                    if (rvalid) begin
                        resp_valid_q <= owner_oh;
                        resp_data_q  <= rdata;
                        err_q        <= beat_err;
                        // Burst ends on beat count only; rlast is merely checked.
                        if (beat_final) begin
                            resp_last_q <= 1'b1;
                            resp_err_q  <= beat_err;
                            cnt_q       <= '0;
                            state_q     <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                StErr: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign arvalid    = (state_q == StAr);
    assign rready     = (state_q == StR);
    assign arid       = 4'(owner_q);
    assign araddr     = addr_q;
    assign arlen      = len_q;
    assign arsize     = size_q;
    assign arburst    = 2'b01;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_22040125_axi_rmaster.sv
// Bench for the AXI read master: a reactive AXI slave plus per-transaction expectations
// derived from the request and the beats the slave actually delivered.
module tb_ysyx_22040125_axi_rmaster;

    localparam int NREQ = 2, DW = 64, AW = 32, MAXLEN = 8;

    logic aclk = 1'b0, areset = 1'b1;
    logic [3:0] arid, rid;
    logic [AW-1:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst, rresp;
    logic arvalid, arready, rlast, rvalid, rready, resp_last, resp_err;
    logic [DW-1:0] rdata, resp_data;
    logic [NREQ-1:0] req_valid = '0, req_ready, resp_valid;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*8-1:0] req_len = '0;
    logic [NREQ*3-1:0] req_size = '0;

    ysyx_22040125_axi_rmaster #(.NREQ(NREQ), .DW(DW), .AW(AW), .MAXLEN(MAXLEN)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err)
    );

    always #5 aclk = ~aclk;

    int ntests = 0, nfail = 0;
    int rr_model = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge.
    int grant_q[$];
    int rown_q[$];
    logic [63:0] rdat_q[$];
    bit rlst_q[$], rerr_q[$];
    logic [3:0] ar_id_q[$];
    logic [31:0] ar_addr_q[$];
    logic [7:0] ar_len_q[$];
    logic [2:0] ar_size_q[$];
    int arv_total = 0, ar_run = 0, ar_unstable = 0, busy_grant = 0, last_cnt = 0, oh_bad = 0;
    logic [46:0] ar_prev = '0;
    bit ar_hs_n = 0, r_hs_n = 0;

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < NREQ; i++) if (v[i]) begin idx = i; n++; end
        return (n == 1) ? idx : -1;
    endfunction

    always @(negedge aclk) begin
        ar_hs_n = arvalid && arready;
        r_hs_n  = rvalid && rready;
        if (!areset) begin
            if (|req_ready) begin
                grant_q.push_back(oh_idx(req_ready));
                if (arvalid || rready) busy_grant++;
            end
            if (arvalid) begin
                if (ar_run > 0 && {araddr, arlen, arsize, arid} !== ar_prev) ar_unstable++;
                ar_prev = {araddr, arlen, arsize, arid};
                ar_run++;
                arv_total++;
                if (arready) begin
                    ar_id_q.push_back(arid); ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(arlen); ar_size_q.push_back(arsize);
                    ar_run = 0;
                end
            end
            if (|resp_valid) begin
                rown_q.push_back(oh_idx(resp_valid));
                rdat_q.push_back(resp_data);
                rlst_q.push_back(resp_last);
                rerr_q.push_back(resp_err);
                if (resp_last) last_cnt++;
            end
        end
    end

    // Reactive slave; knobs select delays, gaps and injected protocol faults by beat index.
    int cfg_ard = 0, cfg_gap = 0, cfg_errb = 255, cfg_early = 255, cfg_badid = 255;
    bit cfg_nolast = 0;
    logic [63:0] sent_q[$];

    initial begin : slave
        int ar_cnt;
        int s_idx;
        bit s_act;
        logic [7:0] s_len;
        logic [3:0] s_id;
        ar_cnt = 0; s_idx = 0; s_act = 0; s_len = '0; s_id = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
        forever begin
            @(posedge aclk); #1;
            if (areset) begin
                ar_cnt = 0; s_act = 0; arready = 0; rvalid = 0; rlast = 0;
            end else begin
                if (ar_hs_n) begin
                    arready = 0; ar_cnt = 0; s_act = 1; s_idx = 0; s_len = arlen; s_id = arid;
                end else if (arvalid) begin
                    if (ar_cnt >= cfg_ard) arready = 1; else ar_cnt++;
                end
                if (r_hs_n) begin
                    rvalid = 0;
                    s_idx++;
                    if (s_idx > int'(s_len)) s_act = 0;
                end
                if (s_act && !rvalid && $urandom_range(0, cfg_gap) == 0) begin
                    rdata = {$urandom, $urandom};
                    sent_q.push_back(rdata);
                    rresp = (s_idx == cfg_errb) ? 2'b10 : 2'b00;
                    rlast = ((s_idx == int'(s_len)) && !cfg_nolast) || (s_idx == cfg_early);
                    rid   = (s_idx == cfg_badid) ? (s_id ^ 4'h1) : s_id;
                    rvalid = 1;
                end
            end
        end
    end

    task automatic clear_mon();
        grant_q.delete(); rown_q.delete(); rdat_q.delete(); rlst_q.delete(); rerr_q.delete();
        ar_id_q.delete(); ar_addr_q.delete(); ar_len_q.delete(); ar_size_q.delete();
        sent_q.delete();
        arv_total = 0; ar_run = 0; ar_unstable = 0; busy_grant = 0; last_cnt = 0;
    endtask

    task automatic run_txn(input string nm, input int r, input logic [31:0] addr, input int len,
                           input int size, input int ard, input int gap, input int errb,
                           input int early, input bit nolast, input int badid);
        int nb, elen;
        bit legal, experr;
        clear_mon();
        cfg_ard = ard; cfg_gap = gap; cfg_errb = errb; cfg_early = early;
        cfg_nolast = nolast; cfg_badid = badid;
        legal  = (size <= 3);
        elen   = (len > MAXLEN - 1) ? MAXLEN - 1 : len;
        nb     = legal ? elen + 1 : 1;
        experr = !legal || (len > MAXLEN - 1) || (errb < nb) || (early < nb - 1) || nolast
                 || (badid < nb);
        req_addr[r*AW +: AW] = addr;
        req_len[r*8 +: 8]    = 8'(len);
        req_size[r*3 +: 3]   = 3'(size);
        req_valid[r]         = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge aclk); #1;
            if (grant_q.size() > 0) break;
        end
        req_valid[r] = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (last_cnt > 0) break;
            @(posedge aclk); #1;
        end
        repeat (3) @(posedge aclk);
        #1;
        check({nm, ".ngrant"}, grant_q.size(), 1);
        if (grant_q.size() > 0) check({nm, ".grant"}, grant_q[0], r);
        rr_model = (r + 1) % NREQ;
        if (legal) begin
            check({nm, ".nar"}, ar_id_q.size(), 1);
            if (ar_id_q.size() > 0) begin
                check({nm, ".arid"}, ar_id_q[0], r);
                check({nm, ".araddr"}, ar_addr_q[0], addr);
                check({nm, ".arlen"}, ar_len_q[0], elen);
                check({nm, ".arsize"}, ar_size_q[0], size);
            end
            check({nm, ".arvcyc"}, arv_total, ard + 1);
        end else begin
            check({nm, ".nar"}, arv_total, 0);
        end
        check({nm, ".arstable"}, ar_unstable, 0);
        check({nm, ".busygrant"}, busy_grant, 0);
        check({nm, ".nbeats"}, rown_q.size(), nb);
        check({nm, ".nlast"}, last_cnt, 1);
        for (int i = 0; i < nb && i < rown_q.size(); i++) begin
            check($sformatf("%s.own%0d", nm, i), rown_q[i], r);
            check($sformatf("%s.data%0d", nm, i), rdat_q[i],
                  (legal && i < sent_q.size()) ? sent_q[i] : 64'd0);
            check($sformatf("%s.last%0d", nm, i), rlst_q[i], i == nb - 1);
            check($sformatf("%s.err%0d", nm, i), rerr_q[i], (i == nb - 1) ? experr : 1'b0);
        end
        check({nm, ".idle"}, {arvalid, rready}, 2'b00);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a0, a1;
        int g;
        // Reset values, with requests pending to show req_ready stays low in reset.
        req_valid = 2'b11;
        repeat (3) @(posedge aclk);
        #1;
        check("rst.req_ready", req_ready, 0);
        check("rst.ctl", {arvalid, rready, resp_valid, resp_last, resp_err}, 0);
        check("rst.ar", {araddr, arlen, arsize, arid}, 0);
        check("rst.resp_data", resp_data, 0);
        check("rst.arburst", arburst, 2'b01);
        req_valid = '0;
        @(posedge aclk); #1;
        areset = 0;
        @(posedge aclk); #1;

        run_txn("single", 0, 32'h8000_0000, 0, 3, 0, 0, 255, 255, 0, 255);
        run_txn("burst", 1, $urandom, 3, 3, 5, 2, 255, 255, 0, 255);
        run_txn("rresp", 0, $urandom, 3, 3, 1, 1, 1, 255, 0, 255);
        run_txn("early", 1, $urandom, 3, 3, 0, 1, 255, 2, 0, 255);
        run_txn("nolast", 0, $urandom, 2, 2, 0, 0, 255, 255, 1, 255);
        run_txn("badid", 1, $urandom, 1, 3, 0, 0, 255, 255, 0, 0);
        run_txn("clamp", 0, $urandom, 11, 2, 0, 1, 255, 255, 0, 255);
        run_txn("badsize", 1, $urandom, 0, 4, 0, 0, 255, 255, 0, 255);

        // Reset in the middle of a 4-beat burst, after its first beat.
        clear_mon();
        cfg_ard = 0; cfg_gap = 1; cfg_errb = 255; cfg_early = 255; cfg_nolast = 0; cfg_badid = 255;
        req_addr[1*AW +: AW] = $urandom; req_len[8 +: 8] = 8'd3; req_size[3 +: 3] = 3'd3;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge aclk); #1;
            if (grant_q.size() > 0) break;
        end
        req_valid[1] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rown_q.size() > 0) break;
            @(posedge aclk); #1;
        end
        check("midrst.beat1", rown_q.size(), 1);
        areset = 1;
        @(posedge aclk); #1;
        check("midrst.out", {arvalid, rready, resp_valid, resp_last}, 0);
        check("midrst.nolast", last_cnt, 0);
        @(posedge aclk); #1;
        areset = 0;
        rr_model = 0;
        @(posedge aclk); #1;

        // Both requesters held across three grants; expect alternation from the pointer.
        clear_mon();
        cfg_ard = 1; cfg_gap = 1;
        a0 = $urandom; a1 = $urandom;
        req_addr = {a1, a0}; req_len = '0; req_size = {3'd3, 3'd3};
        req_valid = 2'b11;
        for (int c = 0; c < 300; c++) begin
            @(posedge aclk); #1;
            if (grant_q.size() >= 3) break;
        end
        req_valid = '0;
        for (int c = 0; c < 300; c++) begin
            if (last_cnt >= 3) break;
            @(posedge aclk); #1;
        end
        repeat (3) @(posedge aclk);
        #1;
        check("arb.ngrant", grant_q.size(), 3);
        check("arb.busygrant", busy_grant, 0);
        for (int k = 0; k < 3 && k < grant_q.size() && k < ar_id_q.size(); k++) begin
            g = (rr_model + k) % NREQ;
            check($sformatf("arb.grant%0d", k), grant_q[k], g);
            check($sformatf("arb.arid%0d", k), ar_id_q[k], g);
            check($sformatf("arb.araddr%0d", k), ar_addr_q[k], (g == 0) ? a0 : a1);
            if (k < rown_q.size()) check($sformatf("arb.own%0d", k), rown_q[k], g);
        end
        rr_model = (rr_model + 3) % NREQ;

        // Randomized transactions with random faults.
        for (int t = 0; t < 8; t++) begin
            run_txn($sformatf("rnd%0d", t), $urandom_range(0, NREQ - 1), $urandom,
                    $urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 2),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 255,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 255,
                    $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 255);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
